// File: rtl/regfile_ctx.sv
`default_nettype none
// ============================================================================
// Module      : regfile_ctx
// Description : Per-core register file with predicate bits and a serial
//               context save/restore engine. Two registered read ports,
//               one write port, one predicate read/write port. Registers
//               0..CTX_REGS-1 are streamed in (LOAD) or out (SAVE) one per
//               cycle over valid/ready handshakes.
// Ports       : clk, rst (sync, active-high)
//               rin0/rout0, rin1/rout1     - registered register reads
//               wen0/win0/wdata0           - register write (IDLE only)
//               rpred/predout              - registered predicate read
//               wpreden/wpred/
//               write_pred_value           - predicate write (IDLE only)
//               ctx_load_*                 - context load stream (sink)
//               ctx_save_*                 - context save stream (source)
//               busy, ctx_done             - transfer status
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_ctx #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 16,
  parameter int NPRED    = 4,
  parameter int CTX_REGS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREGS)-1:0] rin0,
  output logic [DATA_W-1:0]        rout0,
  input  logic [$clog2(NREGS)-1:0] rin1,
  output logic [DATA_W-1:0]        rout1,
  input  logic                     wen0,
  input  logic [$clog2(NREGS)-1:0] win0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic [$clog2(NPRED)-1:0] rpred,
  output logic                     predout,
  input  logic                     wpreden,
  input  logic [$clog2(NPRED)-1:0] wpred,
  input  logic                     write_pred_value,
  input  logic                     ctx_load_start,
  input  logic                     ctx_load_valid,
  input  logic [DATA_W-1:0]        ctx_load_data,
  output logic                     ctx_load_ready,
  input  logic                     ctx_save_start,
  output logic                     ctx_save_valid,
  output logic [DATA_W-1:0]        ctx_save_data,
  input  logic                     ctx_save_ready,
  output logic                     busy,
  output logic                     ctx_done
);

  localparam int c_aw = $clog2(NREGS);
  localparam int c_iw = (CTX_REGS > 1) ? $clog2(CTX_REGS) : 1;
  localparam logic [c_iw-1:0] c_last = c_iw'(CTX_REGS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SAVE = 2'd2
  } state_t;

  state_t              r_state, w_state_next;
  logic [c_iw-1:0]     r_idx, w_idx_next;
  logic                r_done, w_done_next;
  logic [DATA_W-1:0]   r_regs      [NREGS];
  logic [DATA_W-1:0]   w_regs_next [NREGS];
  logic [NPRED-1:0]    r_preds, w_preds_next;
  logic [DATA_W-1:0]   r_rout0, r_rout1;
  logic                r_predout;
  logic                w_idle, w_beat, w_last;

  assign w_idle = (r_state == S_IDLE);
  // A beat is one accepted handshake in whichever direction is active.
  assign w_beat = ((r_state == S_LOAD) && ctx_load_valid) ||
                  ((r_state == S_SAVE) && ctx_save_ready);
  assign w_last = w_beat && (r_idx == c_last);

  // Next-state / transfer control.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Save wins when both starts arrive together; the load request is dropped.
        if (ctx_save_start) begin
          w_state_next = S_SAVE;
          w_idx_next   = '0;
        end else if (ctx_load_start) begin
          w_state_next = S_LOAD;
          w_idx_next   = '0;
        end
      end
      S_LOAD, S_SAVE: begin
        if (w_last) begin
          w_state_next = S_IDLE;
          w_idx_next   = '0;
          w_done_next  = 1'b1;
        end else if (w_beat) begin
          w_idx_next   = r_idx + c_iw'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_idx_next   = '0;
      end
    endcase
  end

  // Next contents of the register and predicate arrays. Reads sample these
  // next values, which gives write-first behaviour for every write source.
  always_comb begin
    w_regs_next  = r_regs;
    w_preds_next = r_preds;
    if ((r_state == S_LOAD) && ctx_load_valid) begin
      w_regs_next[c_aw'(r_idx)] = ctx_load_data;
    end else if (w_idle && wen0) begin
      w_regs_next[win0] = wdata0;
    end
    // A restored context always starts with every predicate set.
    if ((r_state == S_LOAD) && w_last) begin
      w_preds_next = '1;
    end else if (w_idle && wpreden) begin
      w_preds_next[wpred] = write_pred_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_preds   <= '1;
      r_rout0   <= '0;
      r_rout1   <= '0;
      r_predout <= 1'b0;
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_regs    <= w_regs_next;
      r_preds   <= w_preds_next;
      r_rout0   <= w_regs_next[rin0];
      r_rout1   <= w_regs_next[rin1];
      r_predout <= w_preds_next[rpred];
      r_state   <= w_state_next;
      r_idx     <= w_idx_next;
      r_done    <= w_done_next;
    end
  end

  assign rout0          = r_rout0;
  assign rout1          = r_rout1;
  assign predout        = r_predout;
  assign busy           = !w_idle;
  assign ctx_load_ready = (r_state == S_LOAD);
  assign ctx_save_valid = (r_state == S_SAVE);
  // Register contents cannot change during SAVE (writes are dropped while
  // busy), so this is stable while the consumer stalls.
  assign ctx_save_data  = (r_state == S_SAVE) ? r_regs[c_aw'(r_idx)] : '0;
  assign ctx_done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_regfile_ctx.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_ctx
// Description : Self-checking bench for regfile_ctx. A reference model keeps
//               the register file as plain arrays plus a transfer mode and
//               beat count; each clock it queues the expected outputs and a
//               monitor on the falling edge pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_ctx;

  localparam int DATA_W   = 32;
  localparam int NREGS    = 16;
  localparam int NPRED    = 4;
  localparam int CTX_REGS = 8;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_SAVE = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        rin0, rin1, win0;
  logic [DATA_W-1:0] rout0, rout1, wdata0;
  logic              wen0;
  logic [1:0]        rpred, wpred;
  logic              predout, wpreden, write_pred_value;
  logic              ctx_load_start, ctx_load_valid, ctx_load_ready;
  logic [DATA_W-1:0] ctx_load_data, ctx_save_data;
  logic              ctx_save_start, ctx_save_valid, ctx_save_ready;
  logic              busy, ctx_done;

  always #5 clk = ~clk;

  regfile_ctx #(
    .DATA_W(DATA_W), .NREGS(NREGS), .NPRED(NPRED), .CTX_REGS(CTX_REGS)
  ) dut (
    .clk(clk), .rst(rst),
    .rin0(rin0), .rout0(rout0), .rin1(rin1), .rout1(rout1),
    .wen0(wen0), .win0(win0), .wdata0(wdata0),
    .rpred(rpred), .predout(predout),
    .wpreden(wpreden), .wpred(wpred), .write_pred_value(write_pred_value),
    .ctx_load_start(ctx_load_start), .ctx_load_valid(ctx_load_valid),
    .ctx_load_data(ctx_load_data), .ctx_load_ready(ctx_load_ready),
    .ctx_save_start(ctx_save_start), .ctx_save_valid(ctx_save_valid),
    .ctx_save_data(ctx_save_data), .ctx_save_ready(ctx_save_ready),
    .busy(busy), .ctx_done(ctx_done)
  );

  typedef struct {
    logic [31:0] r0, r1, sd;
    logic [31:0] p, bsy, lr, sv, dn;
  } exp_t;

  exp_t        q_exp[$];
  logic [31:0] q_acc[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_done   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_regs [NREGS];
  logic        m_preds [NPRED];
  int          m_mode, m_cnt;

  always @(posedge clk) begin
    exp_t e;
    bit   dn;
    dn = 1'b0;
    if (rst) begin
      for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
      for (int i = 0; i < NPRED; i++) m_preds[i] = 1'b1;
      m_mode = M_IDLE;
      m_cnt  = 0;
    end else begin
      if (m_mode == M_IDLE) begin
        if (wen0) m_regs[win0] = wdata0;
        if (wpreden) m_preds[wpred] = write_pred_value;
        if (ctx_save_start) begin
          m_mode = M_SAVE; m_cnt = 0;
        end else if (ctx_load_start) begin
          m_mode = M_LOAD; m_cnt = 0;
        end
      end else if (m_mode == M_LOAD) begin
        if (ctx_load_valid) begin
          m_regs[m_cnt] = ctx_load_data;
          m_cnt++;
          if (m_cnt == CTX_REGS) begin
            for (int i = 0; i < NPRED; i++) m_preds[i] = 1'b1;
            m_mode = M_IDLE; m_cnt = 0; dn = 1'b1;
          end
        end
      end else begin
        if (ctx_save_ready) begin
          m_cnt++;
          if (m_cnt == CTX_REGS) begin
            m_mode = M_IDLE; m_cnt = 0; dn = 1'b1;
          end
        end
      end
    end
    e.r0  = rst ? 32'h0 : m_regs[rin0];
    e.r1  = rst ? 32'h0 : m_regs[rin1];
    e.p   = rst ? 32'h0 : 32'(m_preds[rpred]);
    e.bsy = 32'(m_mode != M_IDLE);
    e.lr  = 32'(m_mode == M_LOAD);
    e.sv  = 32'(m_mode == M_SAVE);
    e.dn  = 32'(dn);
    e.sd  = (m_mode == M_SAVE) ? m_regs[m_cnt] : 32'h0;
    q_exp.push_back(e);
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      chk("rout0",          rout0,               e.r0);
      chk("rout1",          rout1,               e.r1);
      chk("predout",        32'(predout),        e.p);
      chk("busy",           32'(busy),           e.bsy);
      chk("ctx_load_ready", 32'(ctx_load_ready), e.lr);
      chk("ctx_save_valid", 32'(ctx_save_valid), e.sv);
      chk("ctx_done",       32'(ctx_done),       e.dn);
      chk("ctx_save_data",  ctx_save_data,       e.sd);
    end
    if (ctx_save_valid === 1'b1 && ctx_save_ready === 1'b1) q_acc.push_back(ctx_save_data);
    if (ctx_done === 1'b1) n_done++;
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wen0 = 1'b0; win0 = '0; wdata0 = '0;
    wpreden = 1'b0; wpred = '0; write_pred_value = 1'b0;
    ctx_load_start = 1'b0; ctx_load_valid = 1'b0; ctx_load_data = '0;
    ctx_save_start = 1'b0; ctx_save_ready = 1'b0;
  endtask

  // Streams CTX_REGS beats base+k; stall alternates valid; abort_at >= 0
  // returns early once that many beats have been accepted.
  task automatic load_ctx(input logic [31:0] base, input bit stall, input int abort_at);
    int k = 0;
    int t = 0;
    ctx_load_start = 1'b1;
    cyc();
    ctx_load_start = 1'b0;
    while (k < CTX_REGS && t < 200) begin
      if (abort_at >= 0 && k == abort_at) break;
      ctx_load_valid = stall ? (t % 2 == 1) : 1'b1;
      ctx_load_data  = base + 32'(k);
      // A register write attempted mid-transfer must be dropped.
      wen0   = (t == 2);
      win0   = 4'd3;
      wdata0 = 32'hBAD0_BAD0;
      if (ctx_load_valid && ctx_load_ready) k++;
      cyc();
      t++;
    end
    idle_inputs();
    if (abort_at < 0) chk("load_beats", 32'(k), 32'(CTX_REGS));
  endtask

  task automatic save_ctx(input bit both_starts, output bit lr_seen);
    int k = 0;
    int t = 0;
    lr_seen = 1'b0;
    ctx_save_start = 1'b1;
    ctx_load_start = both_starts;
    cyc();
    ctx_save_start = 1'b0;
    ctx_load_start = 1'b0;
    while (k < CTX_REGS && t < 200) begin
      ctx_save_ready = 1'($urandom);
      if (ctx_load_ready) lr_seen = 1'b1;
      if (ctx_save_valid && ctx_save_ready) k++;
      cyc();
      t++;
    end
    idle_inputs();
    chk("save_beats", 32'(k), 32'(CTX_REGS));
  endtask

  task automatic read_sweep();
    for (int i = 0; i < NREGS; i++) begin
      rin0  = 4'(i);
      rin1  = 4'(NREGS - 1 - i);
      rpred = 2'(i);
      cyc();
    end
  endtask

  task automatic check_saved_seq();
    chk("save_acc_count", 32'(q_acc.size()), 32'(CTX_REGS));
    for (int i = 0; i < CTX_REGS; i++) begin
      if (i < q_acc.size()) chk("save_acc_data", q_acc[i], 32'(i) * 32'h11);
    end
  endtask

  initial begin
    int done_before;
    bit lr_seen;

    rst = 1'b1;
    idle_inputs();
    rin0 = 4'd0; rin1 = 4'd15; rpred = 2'd3;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("reset_busy", 32'(busy), 32'h0);

    // Write-first bypass on register and predicate.
    wen0 = 1'b1; win0 = 4'd5; wdata0 = 32'hDEAD_BEEF; rin0 = 4'd5;
    wpreden = 1'b1; wpred = 2'd2; write_pred_value = 1'b0; rpred = 2'd2;
    cyc();
    idle_inputs();
    cyc();

    // Load with stalls and an ignored mid-transfer write.
    rin0 = 4'd3;
    done_before = n_done;
    load_ctx(32'h100, 1'b1, -1);
    cyc(); cyc();
    chk("load_done_count", 32'(n_done - done_before), 32'h1);
    read_sweep();

    // Preload i*0x11 then save with random backpressure.
    for (int i = 0; i < CTX_REGS; i++) begin
      wen0 = 1'b1; win0 = 4'(i); wdata0 = 32'(i) * 32'h11;
      cyc();
    end
    idle_inputs();
    q_acc.delete();
    save_ctx(1'b0, lr_seen);
    cyc(); cyc();
    check_saved_seq();

    // Simultaneous starts: save must run, load must stay quiet.
    q_acc.delete();
    save_ctx(1'b1, lr_seen);
    cyc(); cyc();
    chk("both_start_load_ready", 32'(lr_seen), 32'h0);
    check_saved_seq();

    // Reset in the middle of a load.
    done_before = n_done;
    load_ctx(32'h200, 1'b0, 3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc(); cyc();
    chk("abort_no_done", 32'(n_done - done_before), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    read_sweep();
    done_before = n_done;
    load_ctx(32'h300, 1'b0, -1);
    cyc(); cyc();
    chk("reload_done_count", 32'(n_done - done_before), 32'h1);
    read_sweep();

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      rin0 = 4'($urandom); rin1 = 4'($urandom); rpred = 2'($urandom);
      wen0 = 1'($urandom); win0 = 4'($urandom); wdata0 = $urandom;
      wpreden = 1'($urandom); wpred = 2'($urandom); write_pred_value = 1'($urandom);
      ctx_load_start = ($urandom % 16 == 0);
      ctx_save_start = ($urandom % 16 == 0);
      ctx_load_valid = 1'($urandom); ctx_load_data = $urandom;
      ctx_save_ready = 1'($urandom);
      cyc();
    end
    idle_inputs();
    ctx_load_valid = 1'b1;
    ctx_save_ready = 1'b1;
    for (int c = 0; c < 20 && busy; c++) cyc();
    idle_inputs();
    chk("drain_idle", 32'(busy), 32'h0);
    read_sweep();
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
